// File: rtl/nes_pad_if.sv
// NES pad scanner bus: pad wires plus the button/event host side.
// The block itself connects through the slave modport.
interface nes_pad_if;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clock;
  logic [7:0] buttons;
  logic       frame_valid;
  logic       evt_pop;
  logic [7:0] evt_data;
  logic       evt_empty;
  logic       evt_overflow;
  logic       clr_overflow;

  modport master (
    output pad_data, evt_pop, clr_overflow,
    input  pad_latch, pad_clock, buttons, frame_valid,
           evt_data, evt_empty, evt_overflow
  );

  modport slave (
    input  pad_data, evt_pop, clr_overflow,
    output pad_latch, pad_clock, buttons, frame_valid,
           evt_data, evt_empty, evt_overflow
  );
endinterface

// File: rtl/nes_pad_scanner.sv
// NES controller scanner: periodically latches and shifts out the pad,
// publishes the button state and queues newly-pressed masks in a FIFO.
// Optional macro PAD_DEBOUNCE_EN: accept a frame only if it matches the
// previous raw frame.
module nes_pad_scanner #(
  parameter int unsigned DIV        = 150,
  parameter int unsigned GAP_TICKS  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic      PCLK,
  input logic      PRESERN,
  nes_pad_if.slave bus
);
  localparam int unsigned BTN_W  = 8;
  localparam int unsigned CNT_W  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int unsigned GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_GAP, S_LATCH, S_SAMPLE, S_CLK_HI, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tcnt_q;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BTN_W-1:0]   shift_q, shift_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [BTN_W-1:0]   buttons_q, buttons_d;
  logic               fv_q, fv_d;
  logic               latch_q, clk_q;
  logic [BTN_W-1:0]   press_c;
  logic               push_c;
  logic               accept_c;
  logic               tick_c;

  logic [BTN_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_q, wr_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic               ovf_q;
  logic               empty_c, full_c, pop_ok_c, push_ok_c, ovf_set_c;

  assign tick_c = (tcnt_q == CNT_W'(DIV));

  // Free-running tick divider, 0..DIV.
  always_ff @(posedge PCLK) begin
    if (PRESERN) tcnt_q <= '0;
    else         tcnt_q <= tick_c ? '0 : tcnt_q + CNT_W'(1);
  end

`ifdef PAD_DEBOUNCE_EN
  logic [BTN_W-1:0] raw_q, raw_d;

  assign accept_c = (shift_q == raw_q);

  // Remember the last raw frame at the end of every scan.
  always_comb begin
    raw_d = raw_q;
    if (state_q == S_DONE) raw_d = shift_q;
  end

  // Raw-frame register.
  always_ff @(posedge PCLK) begin
    if (PRESERN) raw_q <= '0;
    else         raw_q <= raw_d;
  end
`else
  assign accept_c = 1'b1;
`endif

  // Scan sequencer: next state, shift register and frame publication.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    buttons_d = buttons_q;
    fv_d      = 1'b0;
    press_c   = '0;
    push_c    = 1'b0;
    unique case (state_q)
      S_GAP: begin
        if (tick_c) begin
          if (gap_q <= GAP_W'(1)) begin
            state_d = S_LATCH;
            gap_d   = GAP_W'(GAP_TICKS);
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      S_LATCH: begin
        if (tick_c) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (tick_c) begin
          shift_d  = {shift_q[BTN_W-2:0], ~bus.pad_data};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d  = (bitcnt_q == 3'd7) ? S_DONE : S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (tick_c) state_d = S_SAMPLE;
      end
      S_DONE: begin
        state_d  = S_GAP;
        bitcnt_d = 3'd0;
        if (accept_c) begin
          press_c   = shift_q & ~buttons_q;
          push_c    = (press_c != '0);
          buttons_d = shift_q;
          fv_d      = 1'b1;
        end
      end
      default: state_d = S_GAP;
    endcase
  end

  // Sequencer state and registered pad/button outputs.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_q   <= S_GAP;
      gap_q     <= GAP_W'(GAP_TICKS);
      shift_q   <= '0;
      bitcnt_q  <= 3'd0;
      buttons_q <= '0;
      fv_q      <= 1'b0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      buttons_q <= buttons_d;
      fv_q      <= fv_d;
      latch_q   <= (state_d == S_LATCH);
      clk_q     <= (state_d == S_CLK_HI);
    end
  end

  assign empty_c   = (fcnt_q == '0);
  assign full_c    = (fcnt_q == FCNT_W'(FIFO_DEPTH));
  assign pop_ok_c  = bus.evt_pop && !empty_c;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok_c = push_c && (!full_c || pop_ok_c);
  assign ovf_set_c = push_c && full_c && !pop_ok_c;

  // Event FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok_c) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok_c)  rd_q <= rd_q + PTR_W'(1);
      if (push_ok_c && !pop_ok_c)      fcnt_q <= fcnt_q + FCNT_W'(1);
      else if (!push_ok_c && pop_ok_c) fcnt_q <= fcnt_q - FCNT_W'(1);
      ovf_q <= ovf_set_c | (ovf_q & ~bus.clr_overflow);
    end
  end

  // Event storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge PCLK) begin
    if (push_ok_c) mem_q[wr_q] <= press_c;
  end

  assign bus.pad_latch    = latch_q;
  assign bus.pad_clock    = clk_q;
  assign bus.buttons      = buttons_q;
  assign bus.frame_valid  = fv_q;
  assign bus.evt_data     = empty_c ? '0 : mem_q[rd_q];
  assign bus.evt_empty    = empty_c;
  assign bus.evt_overflow = ovf_q;
endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner with a shift-register pad model.
module tb_nes_pad_scanner;
  localparam int DIV        = 3;
  localparam int GAP_TICKS  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TICK       = DIV + 1;

  logic       PCLK = 1'b0;
  logic       PRESERN;
  logic [7:0] frame_r = 8'h00;
  logic [7:0] sh = 8'h00;
  int         n_vec = 0;
  int         n_bad = 0;
  int         lat_w, clk_n, bad_w;
  logic       fv_seen, to_seen;

  nes_pad_if bus ();

  nes_pad_scanner #(
    .DIV       (DIV),
    .GAP_TICKS (GAP_TICKS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .PCLK   (PCLK),
    .PRESERN(PRESERN),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  // Pad model: latch loads the frame (bit 7 first), each clock shifts.
  always @(posedge bus.pad_latch or posedge bus.pad_clock) begin
    if (bus.pad_latch) sh = frame_r;
    else               sh = {sh[6:0], 1'b0};
  end
  assign bus.pad_data = ~sh[7];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic pop_one();
    bus.evt_pop = 1'b1;
    @(posedge PCLK);
    #1 bus.evt_pop = 1'b0;
    @(negedge PCLK);
  endtask

  // Run one frame from GAP; returns at the negedge of the cycle after DONE.
  task automatic scan(input logic [7:0] f, input bit pop_done);
    int cur;
    cur     = 0;
    frame_r = f;
    lat_w   = 0;
    clk_n   = 0;
    bad_w   = 0;
    fv_seen = 1'b0;
    to_seen = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge PCLK);
      if (bus.pad_latch) lat_w++;
      if (bus.pad_latch && bus.pad_clock) bad_w++;
      if (bus.pad_clock) cur++;
      else if (cur > 0) begin
        clk_n++;
        if (cur != TICK) bad_w++;
        cur = 0;
        if (clk_n == 7) begin
          repeat (4) @(posedge PCLK);
          if (pop_done) begin
            #1 bus.evt_pop = 1'b1;
          end
          @(posedge PCLK);
          #1 bus.evt_pop = 1'b0;
          @(negedge PCLK);
          fv_seen = bus.frame_valid;
          to_seen = 1'b0;
          break;
        end
      end
    end
  endtask

  logic [7:0] ovf_frames [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
  logic [7:0] ovf_events [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    int falls;
    logic prev;
    PRESERN          = 1'b1;
    bus.evt_pop      = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_latch",    8'(bus.pad_latch),    8'h00);
    check("rst_clock",    8'(bus.pad_clock),    8'h00);
    check("rst_buttons",  bus.buttons,          8'h00);
    check("rst_fv",       8'(bus.frame_valid),  8'h00);
    check("rst_empty",    8'(bus.evt_empty),    8'h01);
    check("rst_data",     bus.evt_data,         8'h00);
    check("rst_ovf",      8'(bus.evt_overflow), 8'h00);
    @(posedge PCLK);
    #1 PRESERN = 1'b0;

`ifdef PAD_DEBOUNCE_EN
    scan(8'h04, 1'b0);
    check("db1_timeout", 8'(to_seen), 8'h00);
    check("db1_fv",      8'(fv_seen), 8'h00);
    check("db1_buttons", bus.buttons, 8'h00);
    scan(8'h00, 1'b0);
    check("db2_fv",      8'(fv_seen), 8'h00);
    check("db2_buttons", bus.buttons, 8'h00);
    check("db2_empty",   8'(bus.evt_empty), 8'h01);
    scan(8'h04, 1'b0);
    check("db3_fv",      8'(fv_seen), 8'h00);
    check("db3_buttons", bus.buttons, 8'h00);
    scan(8'h04, 1'b0);
    check("db4_fv",      8'(fv_seen), 8'h01);
    check("db4_buttons", bus.buttons, 8'h04);
    check("db4_data",    bus.evt_data, 8'h04);
`else
    // Idle pad: timing of latch and clock pulses.
    scan(8'h00, 1'b0);
    check("f0_timeout",  8'(to_seen), 8'h00);
    check("f0_latch_w",  8'(lat_w),   8'(TICK));
    check("f0_clk_n",    8'(clk_n),   8'd7);
    check("f0_clk_bad",  8'(bad_w),   8'h00);
    check("f0_fv",       8'(fv_seen), 8'h01);
    check("f0_buttons",  bus.buttons, 8'h00);
    check("f0_empty",    8'(bus.evt_empty), 8'h01);
    @(negedge PCLK);
    check("f0_fv_pulse", 8'(bus.frame_valid), 8'h00);

    // A + last button pressed, then the same frame again.
    scan(8'h81, 1'b0);
    check("f81_buttons", bus.buttons, 8'h81);
    check("f81_empty",   8'(bus.evt_empty), 8'h00);
    check("f81_data",    bus.evt_data, 8'h81);
    pop_one();
    check("f81_pop_empty", 8'(bus.evt_empty), 8'h01);
    check("f81_pop_data",  bus.evt_data, 8'h00);
    scan(8'h81, 1'b0);
    check("f81b_fv",      8'(fv_seen), 8'h01);
    check("f81b_buttons", bus.buttons, 8'h81);
    check("f81b_empty",   8'(bus.evt_empty), 8'h01);

    // Pop while empty is ignored.
    frame_r = 8'h00;
    pop_one();
    check("empty_pop_empty", 8'(bus.evt_empty), 8'h01);
    check("empty_pop_data",  bus.evt_data, 8'h00);

    // Overflow: five presses into a four-deep FIFO.
    scan(8'h00, 1'b0);
    check("ovf_pre_buttons", bus.buttons, 8'h00);
    for (int k = 0; k < 5; k++) begin
      scan(ovf_frames[k], 1'b0);
      check("ovf_flag", 8'(bus.evt_overflow), (k == 4) ? 8'h01 : 8'h00);
    end
    check("ovf_buttons", bus.buttons, 8'h1F);
    frame_r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      check("ovf_event", bus.evt_data, ovf_events[k]);
      pop_one();
    end
    check("ovf_drained", 8'(bus.evt_empty), 8'h01);
    check("ovf_sticky",  8'(bus.evt_overflow), 8'h01);
    bus.clr_overflow = 1'b1;
    @(posedge PCLK);
    #1 bus.clr_overflow = 1'b0;
    @(negedge PCLK);
    check("ovf_cleared", 8'(bus.evt_overflow), 8'h00);

    // Full FIFO with a pop in the DONE cycle of a new press.
    scan(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) scan(ovf_frames[k], 1'b0);
    check("full_ovf",  8'(bus.evt_overflow), 8'h00);
    check("full_head", bus.evt_data, 8'h01);
    scan(8'h2F, 1'b1);
    check("pp_buttons", bus.buttons, 8'h2F);
    check("pp_ovf",     8'(bus.evt_overflow), 8'h00);
    frame_r = 8'h42;
    for (int k = 1; k < 4; k++) begin
      check("pp_event", bus.evt_data, ovf_events[k]);
      pop_one();
    end
    check("pp_tail", bus.evt_data, 8'h20);

    // Reset during the 4th SAMPLE aborts the frame.
    falls = 0;
    prev  = 1'b0;
    for (int i = 0; i < 2000 && falls < 3; i++) begin
      @(negedge PCLK);
      if (prev && !bus.pad_clock) falls++;
      prev = bus.pad_clock;
    end
    check("mid_wait", 8'(falls), 8'd3);
    @(posedge PCLK);
    #1 PRESERN = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_latch",   8'(bus.pad_latch),   8'h00);
    check("mid_clock",   8'(bus.pad_clock),   8'h00);
    check("mid_buttons", bus.buttons,         8'h00);
    check("mid_fv",      8'(bus.frame_valid), 8'h00);
    check("mid_empty",   8'(bus.evt_empty),   8'h01);
    check("mid_data",    bus.evt_data,        8'h00);
    @(posedge PCLK);
    #1 PRESERN = 1'b0;
    scan(8'h42, 1'b0);
    check("post_timeout", 8'(to_seen), 8'h00);
    check("post_latch_w", 8'(lat_w),   8'(TICK));
    check("post_clk_n",   8'(clk_n),   8'd7);
    check("post_clk_bad", 8'(bad_w),   8'h00);
    check("post_buttons", bus.buttons, 8'h42);
    check("post_data",    bus.evt_data, 8'h42);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/nes_pad_scanner.md
NES_PAD_SCANNER -- requirements
Module: nes_pad_scanner

Interface
REQ-001 Parameter DIV, default 150, meaning PCLK cycles per tick minus one (tick period = DIV+1 cycles).
REQ-002 Parameter GAP_TICKS, default 16, meaning idle ticks between scan frames.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, 2..16), meaning press-event FIFO entries.
REQ-004 PCLK  in  1  the only clock; all state changes on its rising edge.
REQ-005 PRESERN  in  1  reset; synchronous, active-high (1 = reset).
REQ-006 pad_data  in  1  serial data from the pad, active-low button bits.
REQ-007 pad_latch  out  1  pad latch strobe, registered.
REQ-008 pad_clock  out  1  pad shift clock, registered.
REQ-009 buttons  out  8  current button state, active-high, first-shifted bit in bit 7.
REQ-010 frame_valid  out  1  one-cycle pulse when buttons is updated.
REQ-011 evt_pop  in  1  pop head of event FIFO.
REQ-012 evt_data  out  8  FIFO head, a mask of newly pressed buttons; 8'h00 when empty.
REQ-013 evt_empty  out  1  FIFO empty flag.
REQ-014 evt_overflow  out  1  sticky flag, set when an event was dropped.
REQ-015 clr_overflow  in  1  clears evt_overflow.

Function
REQ-016 The tick counter SHALL count 0..DIV and wrap to 0; tick is asserted in the cycle the count equals DIV.
REQ-017 The FSM SHALL have states GAP, LATCH, SAMPLE, CLK_HI and DONE, and SHALL change state only on tick, except DONE.
REQ-018 GAP SHALL hold for GAP_TICKS ticks and then go to LATCH.
REQ-019 LATCH SHALL drive pad_latch=1 for exactly one tick and then go to SAMPLE.
REQ-020 SAMPLE SHALL, on tick, shift ~pad_data into the LSB of an 8-bit shift register, shift left, and increment a 3-bit bit counter.
REQ-021 From SAMPLE, the FSM SHALL go to DONE when the bit counter was 7 before the increment, and to CLK_HI otherwise.
REQ-022 CLK_HI SHALL drive pad_clock=1 for one tick and then go to SAMPLE, giving exactly 7 pad_clock pulses per frame.
REQ-023 DONE SHALL last exactly one PCLK cycle, then go to GAP with the bit counter cleared.
REQ-024 In DONE, the block SHALL compute press = frame & ~buttons (using the pre-update buttons), update buttons, and pulse frame_valid.
REQ-025 If press != 0, the block SHALL push press into the FIFO; zero masks SHALL never be pushed.
REQ-026 A push to a full FIFO SHALL be dropped and SHALL set evt_overflow, unless evt_pop is asserted in the same cycle; in that case the pop and the push both succeed.
REQ-027 evt_pop while empty SHALL be ignored.
REQ-028 evt_data SHALL be the head entry combinationally from the FIFO storage; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 When clr_overflow coincides with an overflowing push, evt_overflow SHALL end at 1 (set wins).
REQ-030 pad_latch and pad_clock SHALL never be high simultaneously.

Reset
REQ-031 While PRESERN=1, the block SHALL set state=GAP with a full gap count and tick counter 0.
REQ-032 While PRESERN=1, the block SHALL set pad_latch=0, pad_clock=0, buttons=8'h00, frame_valid=0, the shift register to 0 and the bit counter to 0.
REQ-033 While PRESERN=1, the FIFO SHALL be emptied (evt_empty=1, evt_data=8'h00) and evt_overflow cleared.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no buttons update and no event.

Configuration
REQ-035 With PAD_DEBOUNCE_EN defined, DONE SHALL update buttons (and evaluate press) only when frame equals the previous raw frame; the raw-frame register resets to 8'h00.
REQ-036 With PAD_DEBOUNCE_EN defined, frame_valid SHALL pulse only when buttons is updated.
REQ-037 Without PAD_DEBOUNCE_EN, buttons SHALL update on every frame, and no raw-frame register SHALL exist.

Verification
REQ-038 DIV=3, GAP_TICKS=2, pad_data constant 1 -> latch high 4 cycles, 7 clock pulses each 4 cycles high, buttons=8'h00, FIFO stays empty.
REQ-039 Pad model returning A-first pattern 0,1,1,1,1,1,1,0 (active-low) -> buttons=8'h81, one event 8'h81; next identical frame -> no new event.
REQ-040 Frames 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F with no pops, FIFO_DEPTH=4 -> events 01,02,04,08 kept, 10 dropped, evt_overflow=1.
REQ-041 FIFO full and evt_pop asserted in the DONE cycle of a new press 8'h20 -> head advances, 8'h20 is stored at tail, and evt_overflow stays 0.
REQ-042 PRESERN pulsed during the 4th SAMPLE -> outputs return to reset values and the next complete frame scans normally.
REQ-043 With PAD_DEBOUNCE_EN: frame 8'h04 once then 8'h00 -> buttons stays 8'h00; 8'h04 twice -> buttons=8'h04 and event 8'h04.
